// File: rtl/vita_tx_deframer_mc.sv
// Multi-channel VITA-49 TX deframer: parses buffer-pool packets into one FIFO line per
// sample vector of 1..MAXCHAN channels. It includes sequence checking and a local output FIFO.
module vita_tx_deframer_mc #(
  parameter int BASE             = 0,
  parameter int MAXCHAN          = 1,
  parameter int FIFO_SIZE        = 4,
  parameter int USE_TRANS_HEADER = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        clear_seqnum,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  input  logic [35:0]                 data_i,
  input  logic                        src_rdy_i,
  output logic                        dst_rdy_o,
  output logic [85+32*MAXCHAN-1:0]    sample_fifo_o,
  output logic                        sample_fifo_src_rdy_o,
  input  logic                        sample_fifo_dst_rdy_i,
  output logic [31:0]                 current_seqnum,
  output logic [15:0]                 seq_err_count,
  output logic [15:0]                 fifo_occupied,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [31:0]                 debug
);
  localparam int FW    = 85 + 32*MAXCHAN;
  localparam int DEPTH = 1 << FIFO_SIZE;

  typedef enum logic [3:0] {
    S_TRANS_HEADER, S_HEADER, S_STREAMID, S_CLASSID, S_CLASSID2, S_SECS,
    S_TICS, S_TICS2, S_PAYLOAD, S_STORE, S_TRAILER, S_DUMP
  } state_t;

  localparam state_t S_START = (USE_TRANS_HEADER != 0) ? S_TRANS_HEADER : S_HEADER;

  // Next header field after 'cur', skipping absent fields in VITA order.
  function automatic state_t f_field(input state_t cur, input logic sid, input logic cid,
                                     input logic tsi, input logic tsf, input logic pay,
                                     input logic trl);
    if (cur == S_HEADER && sid)                                         return S_STREAMID;
    if ((cur == S_HEADER || cur == S_STREAMID) && cid)                  return S_CLASSID;
    if (cur == S_CLASSID)                                               return S_CLASSID2;
    if ((cur inside {S_HEADER, S_STREAMID, S_CLASSID2}) && tsi)         return S_SECS;
    if ((cur inside {S_HEADER, S_STREAMID, S_CLASSID2, S_SECS}) && tsf) return S_TICS;
    if (cur == S_TICS)                                                  return S_TICS2;
    if (pay)                                                            return S_PAYLOAD;
    if (trl)                                                            return S_TRAILER;
    return S_DUMP;
  endfunction

  state_t r_state, w_next, w_eff, w_store_next;

  logic [2:0]  r_numchan;
  logic        r_drop, r_ignore;
  logic [31:0] r_cur_seqnum;
  logic [3:0]  r_vseq_last;
  logic        r_trans_err;
  logic [15:0] r_seq_err_count;
  logic        r_sid, r_cid, r_tsi, r_tsf, r_trl, r_sob, r_eob;
  logic [31:0] r_secs, r_tics;
  logic [3:0]  r_seq4;
  logic [15:0] r_pw;
  logic [2:0]  r_chan_idx;
  logic [MAXCHAN-1:0][31:0] r_samples;
  logic        r_line_err, r_line_eop, r_line_eof;

  logic [FW-1:0]      r_mem [DEPTH];
  logic [FIFO_SIZE:0] r_wptr, r_rptr, w_count;
  logic               w_fifo_full, w_fifo_space, w_store, w_pop, w_xfer, w_eof;
  logic [FW-1:0]      w_line;

  logic        w_h_sid, w_h_cid, w_h_trl, w_h_tsi, w_h_tsf, w_pay_ok, w_seq_err, w_vend;
  logic [15:0] w_h_len, w_pw;
  logic [4:0]  w_hdr_words;
  logic [16:0] w_overhead;
  logic        w_unused;

  assign w_unused = ^set_data[31:3];

  assign w_count      = r_wptr - r_rptr;
  assign w_fifo_full  = (w_count == (FIFO_SIZE+1)'(DEPTH));
  assign w_fifo_space = ~w_fifo_full;
  assign w_store      = (r_state == S_STORE) & w_fifo_space;
  assign w_pop        = sample_fifo_src_rdy_o & sample_fifo_dst_rdy_i;

  assign dst_rdy_o = ~((r_state == S_STORE) & w_fifo_full);
  assign w_xfer    = src_rdy_i & dst_rdy_o;
  assign w_eof     = data_i[33];

  // STORE also consumes a word, handling it as whatever state follows the store.
  always_comb begin
    w_store_next = S_PAYLOAD;
    if (r_line_eof)      w_store_next = S_START;
    else if (r_line_eop) w_store_next = r_trl ? S_TRAILER : S_DUMP;
  end
  assign w_eff = (r_state == S_STORE) ? w_store_next : r_state;

  assign w_h_sid     = data_i[28];
  assign w_h_cid     = data_i[27];
  assign w_h_trl     = data_i[26];
  assign w_h_tsi     = |data_i[23:22];
  assign w_h_tsf     = |data_i[21:20];
  assign w_h_len     = data_i[15:0];
  assign w_hdr_words = 5'd1 + {4'd0, w_h_sid} + {3'd0, w_h_cid, 1'b0} + {4'd0, w_h_tsi}
                     + {3'd0, w_h_tsf, 1'b0};
  assign w_overhead  = {12'd0, w_hdr_words} + {16'd0, w_h_trl};
  assign w_pay_ok    = {1'b0, w_h_len} > w_overhead;
  assign w_pw        = w_h_len - w_overhead[15:0];
  assign w_seq_err   = r_trans_err | (~r_ignore & (data_i[19:16] != r_vseq_last + 4'd1));
  assign w_vend      = w_eof | (r_chan_idx == r_numchan) | (r_pw == 16'd1);

  always_comb begin
    w_next = r_state;
    if (!(r_state == S_STORE && w_fifo_full)) begin
      w_next = w_eff;
      if (w_xfer) begin
        case (w_eff)
          S_TRANS_HEADER: w_next = w_eof ? S_START : S_HEADER;
          S_HEADER: begin
            if (w_eof)                    w_next = S_START;
            else if (w_seq_err && r_drop) w_next = S_DUMP;
            else w_next = f_field(S_HEADER, w_h_sid, w_h_cid, w_h_tsi, w_h_tsf, w_pay_ok, w_h_trl);
          end
          S_STREAMID, S_CLASSID, S_CLASSID2, S_SECS, S_TICS, S_TICS2:
            w_next = w_eof ? S_START
                           : f_field(w_eff, r_sid, r_cid, r_tsi, r_tsf, r_pw != 16'd0, r_trl);
          S_PAYLOAD:      w_next = w_vend ? S_STORE : S_PAYLOAD;
          S_TRAILER:      w_next = w_eof ? S_START : S_DUMP;
          S_DUMP:         w_next = w_eof ? S_START : S_DUMP;
          default:        w_next = S_START;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_numchan <= '0;
      r_drop    <= 1'b0;
      r_ignore  <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))
        r_numchan <= ({1'b0, set_data[2:0]} >= 4'(MAXCHAN)) ? 3'(MAXCHAN-1) : set_data[2:0];
      if (set_addr == 8'(BASE+1)) begin
        r_drop   <= set_data[0];
        r_ignore <= set_data[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear || clear_seqnum) begin
      r_cur_seqnum <= 32'hFFFF_FFFF;
      r_vseq_last  <= 4'hF;
    end else if (w_xfer && w_eff == S_TRANS_HEADER) begin
      r_cur_seqnum <= data_i[31:0];
    end else if (w_xfer && w_eff == S_HEADER) begin
      r_vseq_last  <= data_i[19:16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state         <= S_START;
      r_trans_err     <= 1'b0;
      r_seq_err_count <= '0;
      {r_sid, r_cid, r_tsi, r_tsf, r_trl, r_sob, r_eob} <= '0;
      r_secs          <= '0;
      r_tics          <= '0;
      r_seq4          <= '0;
      r_pw            <= '0;
      r_chan_idx      <= '0;
      r_samples       <= '0;
      r_line_err      <= 1'b0;
      r_line_eop      <= 1'b0;
      r_line_eof      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        case (w_eff)
          S_TRANS_HEADER: begin
            r_trans_err <= (data_i[31:0] != r_cur_seqnum + 32'd1);
            r_seq4      <= data_i[3:0];
          end
          S_HEADER: begin
            {r_sid, r_cid, r_tsi, r_tsf, r_trl} <= {w_h_sid, w_h_cid, w_h_tsi, w_h_tsf, w_h_trl};
            r_sob      <= data_i[25];
            r_eob      <= data_i[24];
            r_secs     <= '0;
            r_tics     <= '0;
            r_pw       <= w_pay_ok ? w_pw : 16'd0;
            r_chan_idx <= '0;
            if (USE_TRANS_HEADER == 0) r_seq4 <= data_i[19:16];
            if (w_seq_err && r_seq_err_count != 16'hFFFF)
              r_seq_err_count <= r_seq_err_count + 16'd1;
          end
          S_SECS:  r_secs <= data_i[31:0];
          S_TICS2: r_tics <= data_i[31:0];
          S_PAYLOAD: begin
            // Lane 0 starts a new vector, so stale upper lanes are zeroed here.
            for (int j = 0; j < MAXCHAN; j++) begin
              if (3'(j) == r_chan_idx)   r_samples[j] <= data_i[31:0];
              else if (r_chan_idx == '0) r_samples[j] <= '0;
            end
            r_pw <= r_pw - 16'd1;
            if (w_vend) begin
              r_chan_idx <= '0;
              r_line_err <= (r_chan_idx != r_numchan);
              r_line_eop <= w_eof | (r_pw == 16'd1);
              r_line_eof <= w_eof;
            end else begin
              r_chan_idx <= r_chan_idx + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_line = {r_samples, r_line_err, r_tsi, r_sob, r_eob, r_line_eop, 12'd0, r_seq4,
                   r_secs, r_tics};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr[FIFO_SIZE-1:0]] <= w_line;
  end

  assign sample_fifo_o         = r_mem[r_rptr[FIFO_SIZE-1:0]];
  assign sample_fifo_src_rdy_o = (r_wptr != r_rptr);
  assign current_seqnum        = r_cur_seqnum;
  assign seq_err_count         = r_seq_err_count;
  assign fifo_occupied         = 16'(w_count);
  assign fifo_full             = w_fifo_full;
  assign fifo_empty            = (r_wptr == r_rptr);
  assign debug = {r_state, r_chan_idx, r_line_eop, w_store, w_fifo_space, data_i[35:32],
                  src_rdy_i, w_xfer, r_pw};

endmodule

// File: tb/tb_vita_tx_deframer_mc.sv
// Scoreboard bench for vita_tx_deframer_mc: packets are built from a description, expected
// lines are queued at send time and compared as the output FIFO drains.
module tb_vita_tx_deframer_mc;
  localparam int MC = 4;
  localparam int FS = 2;
  localparam int FW = 85 + 32*MC;

  logic          clk = 1'b0;
  logic          reset, clear, clear_seqnum, set_stb;
  logic [7:0]    set_addr;
  logic [31:0]   set_data;
  logic [35:0]   data_i;
  logic          src_rdy_i, dst_rdy_o;
  logic [FW-1:0] sample_fifo_o;
  logic          sample_fifo_src_rdy_o, sample_fifo_dst_rdy_i;
  logic [31:0]   current_seqnum, debug;
  logic [15:0]   seq_err_count, fifo_occupied;
  logic          fifo_full, fifo_empty;

  vita_tx_deframer_mc #(.BASE(0), .MAXCHAN(MC), .FIFO_SIZE(FS), .USE_TRANS_HEADER(1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .clear_seqnum(clear_seqnum),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .sample_fifo_o(sample_fifo_o), .sample_fifo_src_rdy_o(sample_fifo_src_rdy_o),
    .sample_fifo_dst_rdy_i(sample_fifo_dst_rdy_i), .current_seqnum(current_seqnum),
    .seq_err_count(seq_err_count), .fifo_occupied(fifo_occupied), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .debug(debug));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stalls   = 0;
  logic [255:0] sb [$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && sample_fifo_src_rdy_o && sample_fifo_dst_rdy_i) begin
      if (sb.size() == 0) chk("unexpected_line", 256'(sample_fifo_o), 256'd0);
      else                chk("line", 256'(sample_fifo_o), sb.pop_front());
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic send_word(input logic [35:0] w);
    int n;
    data_i = w; src_rdy_i = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (dst_rdy_o) break;
      n++; stalls++;
      if (n > 200) begin
        chk("accept_timeout", 256'd1, 256'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Describe a packet, queue its expected lines (unless dropped), then drive it.
  task automatic send_pkt(input logic [31:0] tseq, input logic [3:0] vseq, input bit sid,
                          input bit has_t, input bit trl, input bit sob, input bit eob,
                          input int npay, input logic [31:0] pbase, input int nch,
                          input bit expect_lines);
    logic [31:0]  w [$];
    logic [31:0]  secs, tics;
    logic [15:0]  len;
    logic [127:0] smp;
    logic [FW-1:0] ln;
    int nl, nlines, cnt;
    secs = 32'h5EC0_0000 + tseq;
    tics = 32'h71C5_0000 + tseq;
    len  = 16'(1 + int'(sid) + (has_t ? 3 : 0) + npay + int'(trl));
    w.push_back(tseq);
    w.push_back({3'b000, sid, 1'b0, trl, sob, eob, has_t ? 2'b01 : 2'b00,
                 has_t ? 2'b01 : 2'b00, vseq, len});
    if (sid) w.push_back(32'h5100_0000 | tseq);
    if (has_t) begin
      w.push_back(secs);
      w.push_back(32'h0000_0000);
      w.push_back(tics);
    end
    for (int i = 0; i < npay; i++) w.push_back(pbase + 32'(i));
    if (trl) w.push_back(32'h7A11_0000);
    if (expect_lines) begin
      nl = nch + 1;
      nlines = (npay + nl - 1) / nl;
      for (int k = 0; k < nlines; k++) begin
        smp = '0; cnt = 0;
        for (int c = 0; c < nl; c++)
          if (k*nl + c < npay) begin
            smp[32*c +: 32] = pbase + 32'(k*nl + c);
            cnt++;
          end
        ln = {smp, cnt < nl, has_t, sob, eob, k == nlines-1, 12'd0, tseq[3:0],
              has_t ? {secs, tics} : 64'd0};
        sb.push_back(256'(ln));
      end
    end
    for (int i = 0; i < w.size(); i++)
      send_word({2'b00, i == w.size()-1, i == 0, w[i]});
    src_rdy_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || !fifo_empty) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 256'(sb.size()), 256'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; clear_seqnum = 1'b0; set_stb = 1'b0;
    set_addr = '0; set_data = '0; data_i = '0; src_rdy_i = 1'b0;
    sample_fifo_dst_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_dst_rdy", 256'(dst_rdy_o), 256'd1);
    chk("rst_src_rdy", 256'(sample_fifo_src_rdy_o), 256'd0);
    chk("rst_empty", 256'(fifo_empty), 256'd1);
    chk("rst_occupied", 256'(fifo_occupied), 256'd0);
    chk("rst_seq_err", 256'(seq_err_count), 256'd0);
    chk("rst_seqnum", 256'(current_seqnum), 256'hFFFF_FFFF);
    @(posedge clk); #1;

    // 1: one channel, stream id and full timestamp, two payload words
    set_reg(8'd0, 32'd0);
    send_pkt(32'd0, 4'd0, 1, 1, 0, 1, 0, 2, 32'hA, 0, 1);
    wait_drain("t1_drain");
    chk("t1_seqnum", 256'(current_seqnum), 256'd0);

    // 2: numchan written above range clamps to 4 lanes; trailer; no stalls
    set_reg(8'd0, 32'd7);
    stalls = 0;
    send_pkt(32'd1, 4'd1, 0, 0, 1, 0, 1, 8, 32'hC0DE_0000, 3, 1);
    chk("t2_stalls", 256'(stalls), 256'd0);
    wait_drain("t2_drain");

    // 3: two channels, odd payload gives a zero-filled short last vector
    set_reg(8'd0, 32'd1);
    send_pkt(32'd2, 4'd2, 0, 0, 0, 0, 0, 3, 32'h3300_0000, 1, 1);
    wait_drain("t3_drain");

    // 4: transport gap with drop enabled, then clean, empty and error-tolerant packets
    set_reg(8'd1, 32'd1);
    send_pkt(32'd5, 4'd3, 0, 0, 0, 0, 0, 4, 32'h4400_0000, 1, 0);
    wait_drain("t4_drop_drain");
    chk("t4_err_count", 256'(seq_err_count), 256'd1);
    chk("t4_seqnum", 256'(current_seqnum), 256'd5);
    send_pkt(32'd6, 4'd4, 0, 0, 0, 1, 1, 2, 32'h4600_0000, 1, 1);
    wait_drain("t4_clean_drain");
    chk("t4_err_after", 256'(seq_err_count), 256'd1);
    send_pkt(32'd7, 4'd5, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    wait_drain("t4_empty_pkt");
    set_reg(8'd1, 32'd3);
    send_pkt(32'd8, 4'd9, 0, 0, 0, 0, 0, 2, 32'h4800_0000, 1, 1);
    wait_drain("t4_ignore_drain");
    chk("t4_ignore_count", 256'(seq_err_count), 256'd1);
    set_reg(8'd1, 32'd0);
    send_pkt(32'd9, 4'd3, 0, 0, 0, 0, 0, 2, 32'h4900_0000, 1, 1);
    wait_drain("t4_vita_err_drain");
    chk("t4_vita_err_count", 256'(seq_err_count), 256'd2);

    // 5: back-pressure until the output FIFO fills
    set_reg(8'd0, 32'd0);
    sample_fifo_dst_rdy_i = 1'b0;
    fork
      send_pkt(32'd10, 4'd4, 0, 0, 0, 0, 0, 6, 32'h5500_0000, 0, 1);
      begin
        int n = 0;
        while (!fifo_full && n < 200) begin @(posedge clk); #1; n++; end
        chk("t5_full", 256'(fifo_full), 256'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_dst_rdy_low", 256'(dst_rdy_o), 256'd0);
        chk("t5_occupied", 256'(fifo_occupied), 256'(1 << FS));
        @(posedge clk); #1;
        sample_fifo_dst_rdy_i = 1'b1;
      end
    join
    wait_drain("t5_drain");

    // 6: clear in the middle of a payload, then a clean packet
    sample_fifo_dst_rdy_i = 1'b0;
    send_word({4'b0001, 32'd11});
    send_word({4'b0000, 16'h0000, 16'd10});
    for (int i = 0; i < 3; i++) send_word({4'b0000, 32'h6600_0000 + 32'(i)});
    src_rdy_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_partial_occ", 256'(fifo_occupied), 256'd3);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("t6_empty", 256'(fifo_empty), 256'd1);
    chk("t6_err_count", 256'(seq_err_count), 256'd0);
    chk("t6_seqnum", 256'(current_seqnum), 256'hFFFF_FFFF);
    chk("t6_dst_rdy", 256'(dst_rdy_o), 256'd1);
    @(posedge clk); #1;
    sample_fifo_dst_rdy_i = 1'b1;
    send_pkt(32'd0, 4'd0, 0, 1, 0, 1, 1, 2, 32'h6A00_0000, 0, 1);
    wait_drain("t6_drain");
    chk("t6_err_after", 256'(seq_err_count), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
